sr_w_pl: RTL and testbench
==========================

SR_W_PL -- requirements
Module: sr_w_pl

Interface
REQ-001 Parameter N, default 8, register width in bits; legal range N >= 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high; sampled only on the rising edge of clk.
REQ-004 IN  input  N  parallel load data.
REQ-005 sel  input  2  operation select, sampled at each rising edge.
REQ-006 OUT  output  N  registered register contents.
REQ-007 Positional port order SHALL be OUT, clk, IN, sel, rst, so existing positional instantiations of (OUT, clk, IN, sel) bind correctly.

Function
REQ-008 The block SHALL hold one N-bit register R, and OUT SHALL equal R at all times, with no combinational path from any input to OUT.
REQ-009 sel = 00 (HOLD): R keeps its value.
REQ-010 sel = 01 (LOAD): R takes IN on the rising edge.
REQ-011 sel = 10 (SHR): R becomes {1'b0, R[N-1:1]}; the LSB is discarded and 0 enters at the MSB.
REQ-012 sel = 11 (SHL): R becomes {R[N-2:0], 1'b0}; the MSB is discarded and 0 enters at the LSB.
REQ-013 Latency SHALL be one clock: the result of the operation sampled at edge k appears on OUT immediately after edge k.
REQ-014 Shifts SHALL be logical (zero fill) and SHALL NOT wrap or rotate; N consecutive shifts in one direction SHALL leave R = 0.
REQ-015 IN SHALL be ignored for every sel other than 01.
REQ-016 The sel value SHALL be re-evaluated every cycle with no mode memory; consecutive cycles with the same sel repeat the operation.
REQ-017 An X or Z on sel SHALL NOT be required to produce defined behaviour; for synthesis, the case statement SHALL be fully specified with HOLD as the default.

Reset
REQ-018 When rst = 1 at a rising edge, R SHALL become all zeros, so OUT = 0 after that edge.
REQ-019 Reset SHALL have priority over every sel operation, including LOAD.
REQ-020 Asserting rst mid-sequence SHALL discard the pending operation; the first edge with rst = 0 SHALL apply the current sel to R = 0.
REQ-021 Before the first reset edge, OUT is undefined; the bench SHALL apply reset first.

Structure
REQ-022 A shared package sr_w_pl_pkg SHALL hold the 2-bit sel encoding constants SEL_HOLD=00, SEL_LOAD=01, SEL_SHR=10 and SEL_SHL=11.
REQ-023 Implementation SHALL be a single module, with one clocked process and one combinational next-state mux.
REQ-024 No sub-module SHALL be used.

Verification (N = 8)
REQ-025 rst=1 for one edge, with any sel and IN -> OUT = 00000000.
REQ-026 LOAD IN=00001111, then HOLD for 2 cycles while IN changes to 00000110 -> OUT = 00001111 throughout.
REQ-027 From 00001111, SHR for one edge -> 00000111; SHL for two edges -> 00001110, then 00011100.
REQ-028 LOAD 10000001, then SHL -> 00000010; LOAD 10000001, then SHR -> 01000000 (boundary bits dropped, zero fill).
REQ-029 LOAD 11111111, then 8 consecutive SHR edges -> 00000000, and OUT stays 0 on further SHR edges.
REQ-030 sel=01, IN=00010100, with rst=1 on the same edge -> OUT = 00000000; the next edge with rst=0 -> OUT = 00010100.

Source files
------------

// File: rtl/sr_w_pl_pkg.sv
// Shared definitions for the sr_w_pl shift/load register.
package sr_w_pl_pkg;

  // Operation select encoding
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_SHL  = 2'b11;

endpackage : sr_w_pl_pkg

// File: rtl/sr_w_pl.sv
// N-bit register with hold, parallel load and logical shift right/left.
// OUT is driven straight from the register, so no input reaches it combinationally.
module sr_w_pl
  import sr_w_pl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  output logic [N-1:0] OUT,
  input  logic         clk,
  input  logic [N-1:0] IN,
  input  logic [1:0]   sel,
  input  logic         rst
);

  logic [N-1:0] r_q;
  logic [N-1:0] r_d;

  // Next-state mux; unknown or unlisted sel values fall back to hold
  always_comb begin
    r_d = r_q;
    case (sel)
      SEL_HOLD: r_d = r_q;
      SEL_LOAD: r_d = IN;
      SEL_SHR:  r_d = {1'b0, r_q[N-1:1]};
      SEL_SHL:  r_d = {r_q[N-2:0], 1'b0};
      default:  r_d = r_q;
    endcase
  end

  // Register update; reset overrides every operation including load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign OUT = r_q;

endmodule : sr_w_pl

// File: tb/tb_sr_w_pl.sv
// Directed self-checking bench for sr_w_pl with N = 8.
module tb_sr_w_pl;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst;
  logic [1:0]   sel;
  logic [N-1:0] din;
  logic [N-1:0] dout;

  int unsigned n_cmp;
  int unsigned n_err;

  sr_w_pl #(
    .N(N)
  ) u_dut (
    .OUT(dout),
    .clk(clk),
    .IN (din),
    .sel(sel),
    .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle before the caller samples
  task automatic step(input logic r, input logic [1:0] s, input logic [N-1:0] d);
    rst = r;
    sel = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    sel = 2'b00;
    din = '0;
    #1;

    // Reset with a load pending
    step(1'b1, 2'b01, 8'hA5);
    check("reset", dout, 8'h00);

    // Load then hold while IN changes
    step(1'b0, 2'b01, 8'b0000_1111);
    check("load_0f", dout, 8'b0000_1111);
    step(1'b0, 2'b00, 8'b0000_0110);
    check("hold_1", dout, 8'b0000_1111);
    step(1'b0, 2'b00, 8'b0000_0110);
    check("hold_2", dout, 8'b0000_1111);

    // Shift right once, left twice
    step(1'b0, 2'b10, 8'h00);
    check("shr_07", dout, 8'b0000_0111);
    step(1'b0, 2'b11, 8'h00);
    check("shl_0e", dout, 8'b0000_1110);
    step(1'b0, 2'b11, 8'h00);
    check("shl_1c", dout, 8'b0001_1100);

    // Boundary bits dropped, no rotate
    step(1'b0, 2'b01, 8'b1000_0001);
    check("load_81a", dout, 8'b1000_0001);
    step(1'b0, 2'b11, 8'h00);
    check("shl_edge", dout, 8'b0000_0010);
    step(1'b0, 2'b01, 8'b1000_0001);
    check("load_81b", dout, 8'b1000_0001);
    step(1'b0, 2'b10, 8'h00);
    check("shr_edge", dout, 8'b0100_0000);

    // IN ignored during a shift
    step(1'b0, 2'b01, 8'b0000_0011);
    step(1'b0, 2'b11, 8'hFF);
    check("shl_ign_in", dout, 8'b0000_0110);

    // Eight right shifts from all ones drain to zero, then stay there
    step(1'b0, 2'b01, 8'hFF);
    check("load_ff", dout, 8'hFF);
    exp = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b10, 8'hFF);
      exp = {1'b0, exp[N-1:1]};
      check($sformatf("shr_drain_%0d", i), dout, exp);
    end

    // Eight left shifts from all ones also drain
    step(1'b0, 2'b01, 8'hFF);
    exp = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'b11, 8'h00);
      exp = {exp[N-2:0], 1'b0};
      check($sformatf("shl_drain_%0d", i), dout, exp);
    end

    // Reset beats a simultaneous load; next edge applies the load
    step(1'b0, 2'b01, 8'h5A);
    step(1'b1, 2'b01, 8'b0001_0100);
    check("rst_vs_load", dout, 8'h00);
    step(1'b0, 2'b01, 8'b0001_0100);
    check("load_after_rst", dout, 8'b0001_0100);

    // Reset mid-shift; next shift operates on zero
    step(1'b1, 2'b11, 8'hFF);
    check("rst_mid_shl", dout, 8'h00);
    step(1'b0, 2'b11, 8'hFF);
    check("shl_after_rst", dout, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sr_w_pl
